// File: rtl/video_palmix.sv
// video_palmix: window/border index select, writable palette lookup and
// blank/init masking, aligned in a fixed two-stage pipeline.
module video_palmix #(
    parameter int IDX_W = 4,
    parameter int COL_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             hpix,
    input  logic             vpix,
    input  logic             hblank,
    input  logic             vblank,
    input  logic [IDX_W-1:0] pixels,
    input  logic [IDX_W-1:0] border,
    input  logic             atm_palwr,
    input  logic [COL_W-1:0] atm_paldata,
    input  logic             pal_we,
    input  logic             pal_re,
    input  logic [IDX_W-1:0] pal_addr,
    input  logic [COL_W-1:0] pal_wdata,
    output logic [COL_W-1:0] pal_rdata,
    output logic             pal_rvalid,
    input  logic             init_req,
    output logic             init_busy,
    output logic [COL_W-1:0] color
);

    localparam int DEPTH = 1 << IDX_W;

    typedef enum logic {S_INIT, S_RUN} state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] icnt_q, icnt_d;

    logic             wr_en;
    logic [IDX_W-1:0] wr_addr;
    logic [COL_W-1:0] wr_data;

    logic [COL_W-1:0] pal_mem [DEPTH];

    logic [IDX_W-1:0] idx;
    logic             rd_fire;

    logic [IDX_W-1:0] idx_s1_q;
    logic             blank_s1_q;
    logic             busy_s1_q;
    logic             s1_vld_q;
    logic [COL_W-1:0] color_q;
    logic [COL_W-1:0] rdata_q;
    logic             rvalid_q;

    assign idx       = (hpix & vpix) ? pixels : border;
    assign init_busy = (state_q == S_INIT);
    assign rd_fire   = pal_re & (state_q == S_RUN);

    // State register and init counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_INIT;
            icnt_q  <= '0;
        end else begin
            state_q <= state_d;
            icnt_q  <= icnt_d;
        end
    end

    // Next state plus the single RAM write port: init > addressed > legacy.
    always_comb begin
        state_d = state_q;
        icnt_d  = icnt_q;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        case (state_q)
            S_INIT: begin
                wr_en   = 1'b1;
                wr_addr = icnt_q;
                wr_data = COL_W'(icnt_q);
                if (init_req) begin
                    icnt_d = '0;
                end else if (icnt_q == '1) begin
                    state_d = S_RUN;
                    icnt_d  = '0;
                end else begin
                    icnt_d = icnt_q + 1'b1;
                end
            end
            default: begin
                if (pal_we) begin
                    wr_en   = 1'b1;
                    wr_addr = pal_addr;
                    wr_data = pal_wdata;
                end else if (atm_palwr) begin
                    wr_en   = 1'b1;
                    wr_addr = idx;
                    wr_data = atm_paldata;
                end
                if (init_req) begin
                    state_d = S_INIT;
                    icnt_d  = '0;
                end
            end
        endcase
    end

    // Palette RAM; reads elsewhere see the pre-edge contents (read-before-write).
    always_ff @(posedge clk) begin
        if (wr_en) pal_mem[wr_addr] <= wr_data;
    end

    // Stage 1: capture index, blank and init flag. s1_vld_q keeps the first
    // post-reset lookup (from reset-valued stage-1 regs) masked to black.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_s1_q   <= '0;
            blank_s1_q <= 1'b0;
            busy_s1_q  <= 1'b0;
            s1_vld_q   <= 1'b0;
        end else begin
            idx_s1_q   <= idx;
            blank_s1_q <= hblank | vblank;
            busy_s1_q  <= init_busy;
            s1_vld_q   <= 1'b1;
        end
    end

    // Stage 2: palette lookup with blank/init masking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            color_q <= '0;
        end else if (!s1_vld_q || blank_s1_q || busy_s1_q) begin
            color_q <= '0;
        end else begin
            color_q <= pal_mem[idx_s1_q];
        end
    end

    // CPU read-back port, only serviced in RUN; data holds between reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            rvalid_q <= rd_fire;
            if (rd_fire) rdata_q <= pal_mem[pal_addr];
        end
    end

    assign color      = color_q;
    assign pal_rdata  = rdata_q;
    assign pal_rvalid = rvalid_q;

endmodule
